// File: rtl/program_memory.sv
// Word-organised program store with auto-incrementing loader, registered PC fetch and a clear sweep.
// Optional macro PROGRAM_MEMORY_WRAP_EN: writes while full wrap circularly instead of being dropped.
`ifndef BYTE_SIZE
`define BYTE_SIZE 8
`endif

module program_memory #(
    parameter int unsigned WORD_SIZE_IN_BYTES = 4,
    parameter int unsigned MEM_SIZE_IN_WORDS  = 64,
    localparam int unsigned POINTER_SIZE = $clog2(MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES),
    localparam int unsigned COUNT_SIZE   = $clog2(MEM_SIZE_IN_WORDS + 1),
    localparam int unsigned WORD_W       = WORD_SIZE_IN_BYTES * `BYTE_SIZE
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_instruction_write,
    input  logic [WORD_W-1:0]       i_instruction,
    input  logic [POINTER_SIZE-1:0] i_pc,
    output logic [WORD_W-1:0]       o_instruction,
    output logic [COUNT_SIZE-1:0]   o_write_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow,
    output logic                    o_misaligned,
    output logic                    o_busy
);

    localparam int unsigned ADDR_W   = $clog2(MEM_SIZE_IN_WORDS);
    localparam int unsigned OFFSET_W = $clog2(WORD_SIZE_IN_BYTES);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [WORD_W-1:0] mem [MEM_SIZE_IN_WORDS];

    logic [0:0]            state, state_next;
    logic [ADDR_W-1:0]     sweep, sweep_next;
    logic [ADDR_W-1:0]     wr_ptr, wr_ptr_next;
    logic [COUNT_SIZE-1:0] count_next;
    logic                  overflow_next;
    logic                  busy_next;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [WORD_W-1:0]     mem_data;

    logic                    aligned;
    logic [POINTER_SIZE-1:0] fetch_index;
    logic                    read_ok;

    assign o_full  = (o_write_count == COUNT_SIZE'(MEM_SIZE_IN_WORDS));
    assign o_empty = (o_write_count == '0);

    // Fetch qualification: aligned, loaded, in range, and not sweeping
    assign aligned     = ((i_pc & POINTER_SIZE'(WORD_SIZE_IN_BYTES - 1)) == '0);
    assign fetch_index = i_pc >> OFFSET_W;
    assign read_ok     = aligned
                      && (32'(fetch_index) < 32'(o_write_count))
                      && (32'(fetch_index) < MEM_SIZE_IN_WORDS)
                      && (state == IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            sweep         <= '0;
            wr_ptr        <= '0;
            o_write_count <= '0;
            o_overflow    <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_next;
            sweep         <= sweep_next;
            wr_ptr        <= wr_ptr_next;
            o_write_count <= count_next;
            o_overflow    <= overflow_next;
            o_busy        <= busy_next;
        end
    end

    always_comb begin
        state_next    = state;
        sweep_next    = sweep;
        wr_ptr_next   = wr_ptr;
        count_next    = o_write_count;
        overflow_next = o_overflow;
        busy_next     = o_busy;
        mem_we        = 1'b0;
        mem_addr      = wr_ptr;
        mem_data      = i_instruction;

        case (state)
            IDLE: begin
                if (i_clear) begin
                    state_next    = CLEAR;
                    sweep_next    = '0;
                    wr_ptr_next   = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    busy_next     = 1'b1;
                end else if (i_instruction_write) begin
                    if (!o_full) begin
                        mem_we      = 1'b1;
                        count_next  = o_write_count + COUNT_SIZE'(1);
                        wr_ptr_next = (wr_ptr == ADDR_W'(MEM_SIZE_IN_WORDS - 1))
                                    ? '0 : wr_ptr + ADDR_W'(1);
                    end else begin
                        overflow_next = 1'b1;
`ifdef PROGRAM_MEMORY_WRAP_EN
                        mem_we      = 1'b1;
                        wr_ptr_next = (wr_ptr == ADDR_W'(MEM_SIZE_IN_WORDS - 1))
                                    ? '0 : wr_ptr + ADDR_W'(1);
`endif
                    end
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = sweep;
                mem_data = '0;
                if (sweep == ADDR_W'(MEM_SIZE_IN_WORDS - 1)) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    sweep_next = sweep + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage array is deliberately not reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_instruction <= '0;
            o_misaligned  <= 1'b0;
        end else begin
            o_instruction <= read_ok ? mem[ADDR_W'(fetch_index)] : '0;
            o_misaligned  <= !aligned;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: reference model checked every cycle plus directed literal checks.
module tb_program_memory;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] din = '0;
    logic [7:0]  pc = '0;
    logic [31:0] instr;
    logic [6:0]  count;
    logic        full, empty, overflow, misaligned, busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    program_memory dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_clear             (clear),
        .i_instruction_write (wr),
        .i_instruction       (din),
        .i_pc                (pc),
        .o_instruction       (instr),
        .o_write_count       (count),
        .o_full              (full),
        .o_empty             (empty),
        .o_overflow          (overflow),
        .o_misaligned        (misaligned),
        .o_busy              (busy)
    );

    always #5 clk = ~clk;

    // Reference model: array plus counters, updated from the rules per clock edge
    logic [31:0] m_mem [DEPTH];
    int          m_count = 0;
    int          m_wptr = 0;
    int          m_left = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] e_instr = '0;
    bit          e_mis = 1'b0;
    int          m_idx;
    bit          m_al;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_wptr = 0; m_left = 0; m_ovf = 1'b0;
            e_instr = '0; e_mis = 1'b0;
        end else begin
            m_al  = (int'(pc) % 4) == 0;
            m_idx = int'(pc) / 4;
            e_mis = !m_al;
            e_instr = (m_al && m_idx < m_count && m_idx < DEPTH && m_left == 0) ? m_mem[m_idx] : 32'h0;
            if (m_left > 0) begin
                m_mem[DEPTH - m_left] = '0;
                m_left--;
            end else if (clear) begin
                m_count = 0; m_ovf = 1'b0; m_left = DEPTH; m_wptr = 0;
            end else if (wr) begin
`ifdef PROGRAM_MEMORY_WRAP_EN
                m_mem[m_wptr] = din;
                m_wptr = (m_wptr + 1) % DEPTH;
                if (m_count < DEPTH) m_count++;
                else m_ovf = 1'b1;
`else
                if (m_count < DEPTH) begin
                    m_mem[m_count] = din;
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_instr",    instr, e_instr);
            chk("m_mis",      32'(misaligned), 32'(e_mis));
            chk("m_count",    32'(count), 32'(m_count));
            chk("m_full",     32'(full), 32'(m_count == DEPTH));
            chk("m_empty",    32'(empty), 32'(m_count == 0));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_busy",     32'(busy), 32'(m_left > 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] w);
        wr = 1'b1; din = w;
        step();
        wr = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        pc = a;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    logic [31:0] words [10];
    logic [31:0] seed_dummy;
    logic [31:0] exp0;
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        seed_dummy = $urandom(356815353);
        rst = 1'b1;
        step(); step();
        cmp_en = 1'b1;
        chk("reset_instr", instr, 32'h0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Ten random words at random gaps
        for (int i = 0; i < 10; i++) begin
            words[i] = $urandom;
            do_write(words[i]);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
        chk("load_count", 32'(count), 32'd10);
        chk("load_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 10; i++) begin
            fetch(8'(i * 4));
            chk("fetch_word", instr, words[i]);
        end
        fetch(8'd40);
        chk("unloaded_instr", instr, 32'h0);
        chk("unloaded_mis", 32'(misaligned), 32'd0);
        fetch(8'd6);
        chk("misaligned_instr", instr, 32'h0);
        chk("misaligned_flag", 32'(misaligned), 32'd1);

        // Fill remaining words then one extra write
        for (int i = 10; i < 64; i++) do_write(32'h1000_0000 + 32'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf_before", 32'(overflow), 32'd0);
        do_write(32'hDEADBEEF);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd64);
        fetch(8'd0);
`ifdef PROGRAM_MEMORY_WRAP_EN
        exp0 = 32'hDEADBEEF;
`else
        exp0 = words[0];
`endif
        chk("ovf_pc0", instr, exp0);
        fetch(8'd252);
        chk("last_word", instr, 32'h1000_003F);

        // Clear with simultaneous write, then writes held during the sweep
        do_reset();
        for (int i = 0; i < 5; i++) do_write(32'h2000_0000 + 32'(i));
        chk("five_count", 32'(count), 32'd5);
        clear = 1'b1; wr = 1'b1; din = 32'h0BAD_0BAD; pc = 8'd0;
        step();
        clear = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
        wr = 1'b0;
        chk("busy_cycles", 32'(n), 32'd64);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_ovf", 32'(overflow), 32'd0);
        do_write(32'h12345678);
        fetch(8'd0);
        chk("post_clear_pc0", instr, 32'h12345678);

        // Asynchronous reset in the middle of a sweep
        for (int i = 0; i < 3; i++) do_write(32'h3000_0000 + 32'(i));
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sweep_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        step();
        rst = 1'b0;
        step();
        do_write(32'hCAFEF00D);
        fetch(8'd0);
        chk("post_abort_pc0", instr, 32'hCAFEF00D);

        // Write and fetch the same index in one cycle
        do_reset();
        for (int i = 0; i < 3; i++) do_write(32'h4000_0000 + 32'(i));
        pc = 8'd12; wr = 1'b1; din = 32'hA5A5_0003;
        step();
        wr = 1'b0;
        chk("same_cycle_instr", instr, 32'h0);
        step();
        chk("next_fetch_instr", instr, 32'hA5A5_0003);
        step();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_memory.md
Name: program_memory

Overview:
- Parametrised successor to the fetch-stage instruction memory.
- Word-organised, byte-addressed program store with a sequential loader port: each write lands at an auto-incrementing pointer.
- Registered read port addressed by PC.
- Adds occupancy/overflow status, a multi-cycle clear sweep with busy handshake, and zero (NOP) return for misaligned, unloaded or out-of-range fetches.

Parameters:
- WORD_SIZE_IN_BYTES, 4, bytes per instruction word; must be a power of two.
- MEM_SIZE_IN_WORDS, 64, depth in words; any value >= 2.
- POINTER_SIZE (localparam), $clog2(MEM_SIZE_IN_WORDS*WORD_SIZE_IN_BYTES), byte-address width.
- COUNT_SIZE (localparam), $clog2(MEM_SIZE_IN_WORDS+1), write-count width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  single-cycle request to start the clear sweep.
- i_instruction_write  in  1  write strobe; one word stored per high cycle.
- i_instruction  in  WORD_SIZE_IN_BYTES*`BYTE_SIZE  word to load.
- i_pc  in  POINTER_SIZE  byte address for fetch.
- o_instruction  out  WORD_SIZE_IN_BYTES*`BYTE_SIZE  registered fetched word.
- o_write_count  out  COUNT_SIZE  words loaded since last reset/clear.
- o_full  out  1  o_write_count == MEM_SIZE_IN_WORDS.
- o_empty  out  1  o_write_count == 0.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_misaligned  out  1  registered with o_instruction; last fetch address not word-aligned.
- o_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async, immediate):
  - Outputs: o_instruction=0, o_write_count=0, o_full=0, o_empty=1, o_overflow=0, o_misaligned=0, o_busy=0.
  - FSM enters IDLE; sweep index=0.
  - Array contents are not reset.
- Word index = i_pc >> log2(WORD_SIZE_IN_BYTES). Aligned = low log2(WORD_SIZE_IN_BYTES) bits of i_pc are zero.
- Read, 1-cycle latency: on each edge o_instruction <= mem[index] only if all of the following hold; otherwise 0.
  - aligned
  - index < o_write_count
  - index < MEM_SIZE_IN_WORDS
  - FSM in IDLE
- o_misaligned is registered on the same edge as o_instruction, for the same address.
- Write: in IDLE with i_instruction_write=1 and not full:
  - mem[o_write_count] <= i_instruction; o_write_count += 1.
  - A write and a read of the same index in the same cycle returns the old (zero/unloaded) value. No write-through.
- Write while full: word dropped, count unchanged, o_overflow <= 1 (sticky until reset or clear start).
- FSM states:
  - IDLE: i_clear=1 -> CLEAR.
    - On the transition: o_write_count <= 0, o_overflow <= 0, sweep index <= 0, o_busy <= 1.
    - Clear has priority over a simultaneous write; that write is dropped and not counted.
  - CLEAR: each cycle mem[sweep index] <= 0, index += 1.
    - After writing index MEM_SIZE_IN_WORDS-1 -> IDLE, o_busy <= 0.
    - Sweep lasts exactly MEM_SIZE_IN_WORDS cycles.
    - i_clear and i_instruction_write are ignored (no count, no overflow).
    - Reads return 0 with o_misaligned still computed.
- Reset mid-sweep: aborts to IDLE; remaining words are unswept but unreadable because count=0.
- o_full and o_empty are combinational from o_write_count.

Optional Feature:
- Macro: PROGRAM_MEMORY_WRAP_EN.
- Defined:
  - Write while full stores at index 0 and continues circularly; a write pointer separate from the count wraps modulo MEM_SIZE_IN_WORDS.
  - o_write_count saturates at MEM_SIZE_IN_WORDS.
  - o_overflow sets on the first wrapped write.
  - Once full, all in-range aligned indices are readable.
- Undefined: saturating behaviour as above; extra writes are dropped.

Test Plan:
- Reset, then 10 writes of seed-356815353 random words at random gaps -> o_write_count=10, o_empty=0. Fetch PC 0,4,..,36: each o_instruction equals its written word one cycle after the PC is applied.
- Fetch PC=40 (unloaded) and PC=6 (misaligned) -> o_instruction=0 for both; o_misaligned=0 for PC=40 and 1 for PC=6.
- Fill all 64 words, then write 0xDEADBEEF -> o_full=1, o_overflow=1, count=64, PC=0 still returns the first word. With PROGRAM_MEMORY_WRAP_EN: PC=0 returns 0xDEADBEEF.
- From 5 loaded words, assert i_clear and i_instruction_write together:
  - o_busy high for exactly 64 cycles; count=0; o_overflow=0.
  - Writes during the sweep are ignored.
  - After the sweep, a write of 0x12345678 lands at PC=0.
- Assert i_reset asynchronously mid-sweep (cycle 20) -> o_busy drops without a clock edge; count=0, o_empty=1. A subsequent write and fetch of PC=0 returns the new word.
- Write and fetch the same index (index 3) in the same cycle -> o_instruction=0 that cycle; the written value is returned on the next fetch.
